// File: rtl/pid_ctrl_sat.sv
// pid_ctrl_sat -- three-stage pipelined PID controller with anti-windup
// integrator clamp, runtime speed scaling and output saturation.
//
// Ports:
//   clk, rst          rising-edge clock, synchronous active-high reset
//   error             signed sample error (ERR_W)
//   error_ready       error valid this cycle; one sample per asserted cycle
//   kp, ki, kd        signed fixed-point gains (FRAC_BITS fraction bits)
//   speed_level       output scale level 0-9 (10-15 act as 9)
//   clear_integral    zero the integrator and restart derivative history
//   control_output    saturated control value (OUT_W), held between results
//   control_valid     one-cycle pulse per completed result
//   saturated         control_output was clipped for this result
module pid_ctrl_sat #(
    parameter int ERR_W     = 32,
    parameter int GAIN_W    = 16,
    parameter int FRAC_BITS = 8,
    parameter int OUT_W     = 16,
    parameter int INT_LIM   = 2**20
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic signed [ERR_W-1:0] error,
    input  logic                    error_ready,
    input  logic signed [GAIN_W-1:0] kp,
    input  logic signed [GAIN_W-1:0] ki,
    input  logic signed [GAIN_W-1:0] kd,
    input  logic [3:0]              speed_level,
    input  logic                    clear_integral,
    output logic signed [OUT_W-1:0] control_output,
    output logic                    control_valid,
    output logic                    saturated
);

    localparam int STAGES = 3;
    localparam int IW     = ERR_W + 1;          // integrator / derivative width
    localparam int SW     = ERR_W + GAIN_W + 4; // term and sum width
    localparam int XW     = SW + 5;             // scaled width (x10 headroom)

    localparam logic signed [IW:0]   LIM_P = (IW+1)'(INT_LIM);
    localparam logic signed [IW:0]   LIM_N = -LIM_P;
    localparam logic signed [XW-1:0] OMAX  = XW'(2**(OUT_W-1) - 1);
    localparam logic signed [XW-1:0] OMIN  = -OMAX - XW'(1);

    // controller state
    logic signed [IW-1:0]    integ;
    logic signed [ERR_W-1:0] err_prev;
    logic                    first;

    // pipeline
    logic [STAGES:1]         vld_pipe;
    logic signed [SW-1:0]    p_t, i_t, d_t;
    logic [3:0]              lvl1, lvl2;
    logic signed [SW-1:0]    sh2;

    // S1 combinational: clear_integral in the same cycle as a sample makes
    // that sample see a zero integrator and no derivative history.
    logic signed [IW-1:0] integ_b, integ_next, deriv;
    logic signed [IW:0]   isum;
    logic                 first_eff;

    always_comb begin
        integ_b   = clear_integral ? '0 : integ;
        first_eff = first | clear_integral;
        // one extra bit so integ + error cannot wrap before the clamp
        isum = $signed({integ_b[IW-1], integ_b}) +
               $signed({{2{error[ERR_W-1]}}, error});
        if (isum > LIM_P)
            integ_next = LIM_P[IW-1:0];
        else if (isum < LIM_N)
            integ_next = LIM_N[IW-1:0];
        else
            integ_next = isum[IW-1:0];
        if (first_eff)
            deriv = '0;
        else
            deriv = $signed({error[ERR_W-1], error}) -
                    $signed({err_prev[ERR_W-1], err_prev});
    end

    // S2 combinational: sum then floor shift
    logic signed [SW-1:0] sum2;
    always_comb begin
        sum2 = p_t + i_t + d_t;
    end

    // S3 combinational: scale by min(level,9)+1 and clip
    logic [4:0]           mult;
    logic signed [XW-1:0] scaled;
    always_comb begin
        mult   = ((lvl2 > 4'd9) ? 5'd9 : {1'b0, lvl2}) + 5'd1;
        scaled = XW'(sh2) * $signed({{SW{1'b0}}, mult});
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            integ          <= '0;
            err_prev       <= '0;
            first          <= 1'b1;
            vld_pipe       <= '0;
            p_t            <= '0;
            i_t            <= '0;
            d_t            <= '0;
            lvl1           <= '0;
            lvl2           <= '0;
            sh2            <= '0;
            control_output <= '0;
            control_valid  <= 1'b0;
            saturated      <= 1'b0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:1], error_ready};

            if (error_ready) begin
                integ    <= integ_next;
                err_prev <= error;
                first    <= 1'b0;
            end else if (clear_integral) begin
                integ <= '0;
                first <= 1'b1;
            end

            // S1: gains and level are captured with the sample
            if (error_ready) begin
                p_t  <= SW'(kp) * SW'(error);
                i_t  <= SW'(ki) * SW'(integ_next);
                d_t  <= SW'(kd) * SW'(deriv);
                lvl1 <= speed_level;
            end

            // S2
            if (vld_pipe[1]) begin
                sh2  <= sum2 >>> FRAC_BITS;
                lvl2 <= lvl1;
            end

            // S3
            control_valid <= vld_pipe[2];
            if (vld_pipe[2]) begin
                if (scaled > OMAX) begin
                    control_output <= OMAX[OUT_W-1:0];
                    saturated      <= 1'b1;
                end else if (scaled < OMIN) begin
                    control_output <= OMIN[OUT_W-1:0];
                    saturated      <= 1'b1;
                end else begin
                    control_output <= scaled[OUT_W-1:0];
                    saturated      <= 1'b0;
                end
            end
        end
    end

endmodule
